// File: rtl/kgd_vram_arbiter_if.sv
// kgd_vram_arbiter_if
// Bundles the CPU Wishbone slave path, the screen-clear controls and the
// VRAM port A pins that the arbiter sits between.
// The arbiter uses the slave modport; the bus/RAM side uses the master modport.
interface kgd_vram_arbiter_if #(
    parameter int AW = 14
);
    logic [AW-1:0] wb_adr_i;
    logic [7:0]    wb_dat_i;
    logic [7:0]    wb_dat_o;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_ack_o;

    logic          clr_start;
    logic [7:0]    clr_data;
    logic          clr_busy;
    logic          clr_done;

    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_data;
    logic          vram_wren;
    logic [7:0]    vram_q;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o,
        input  clr_start, clr_data,
        output clr_busy, clr_done,
        output vram_addr, vram_data, vram_wren,
        input  vram_q
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o,
        output clr_start, clr_data,
        input  clr_busy, clr_done,
        input  vram_addr, vram_data, vram_wren,
        output vram_q
    );
endinterface

// File: rtl/kgd_vram_arbiter.sv
// kgd_vram_arbiter
// Shares VRAM port A between the CPU Wishbone slave path and the hardware
// screen-clear engine. The CPU always wins; the clear sweep only writes in
// IDLE cycles with no CPU request, one byte per free cycle.
// All vram_* outputs are combinational so the BRAM samples them at the same
// edge that advances the state machine.
module kgd_vram_arbiter #(
    parameter int AW       = 14,
    parameter int CLR_LAST = 16383
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    kgd_vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(CLR_LAST);

    state_t        r_state;
    state_t        w_nextState;
    logic [AW-1:0] r_counter;
    logic [7:0]    r_fill;
    logic [7:0]    r_rdData;
    logic          r_clrBusy;
    logic          r_clrDone;

    logic          w_ack;
    logic          w_req;
    logic          w_sweepWrite;
    logic          w_sweepLast;
    logic          w_startAccept;
    logic [AW-1:0] w_vramAddr;
    logic [7:0]    w_vramData;
    logic          w_vramWren;

    // Ack is held back while reset is asserted so an aborted access never acks.
    assign w_ack         = (r_state == ST_ACK) & ~wb_rst_i;
    assign w_req         = bus.wb_cyc_i & bus.wb_stb_i & ~w_ack;
    assign w_sweepLast   = w_sweepWrite & (r_counter == LAST_ADDR);
    assign w_startAccept = bus.clr_start & ~r_clrBusy;

    assign bus.wb_ack_o  = w_ack;
    assign bus.wb_dat_o  = r_rdData;
    assign bus.clr_busy  = r_clrBusy;
    assign bus.clr_done  = r_clrDone;
    assign bus.vram_addr = w_vramAddr;
    assign bus.vram_data = w_vramData;
    assign bus.vram_wren = w_vramWren;

    // State register for the IDLE/RD/ACK access sequencer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and port A drive; CPU first, then the sweep, otherwise quiet.
    always_comb begin
        w_nextState  = r_state;
        w_vramAddr   = '0;
        w_vramData   = '0;
        w_vramWren   = 1'b0;
        w_sweepWrite = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_vramAddr = bus.wb_adr_i;
                    if (bus.wb_we_i) begin
                        w_vramData  = bus.wb_dat_i;
                        w_vramWren  = 1'b1;
                        w_nextState = ST_ACK;
                    end else begin
                        w_nextState = ST_RD;
                    end
                end else if (r_clrBusy) begin
                    w_vramAddr   = r_counter;
                    w_vramData   = r_fill;
                    w_vramWren   = 1'b1;
                    w_sweepWrite = 1'b1;
                end
            end
            ST_RD: begin
                w_vramAddr  = bus.wb_adr_i;
                w_nextState = ST_ACK;
            end
            ST_ACK: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (wb_rst_i) begin
            w_vramAddr   = '0;
            w_vramData   = '0;
            w_vramWren   = 1'b0;
            w_sweepWrite = 1'b0;
        end
    end

    // Capture the BRAM output during RD so it is stable through the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rdData <= '0;
        end else if (r_state == ST_RD) begin
            r_rdData <= bus.vram_q;
        end
    end

    // Sweep engine: start only when idle, advance on each granted fill write.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_counter <= '0;
            r_fill    <= '0;
            r_clrBusy <= 1'b0;
            r_clrDone <= 1'b0;
        end else begin
            r_clrDone <= 1'b0;
            if (w_startAccept) begin
                r_fill    <= bus.clr_data;
                r_counter <= '0;
                r_clrBusy <= 1'b1;
            end else if (w_sweepWrite) begin
                if (w_sweepLast) begin
                    r_counter <= '0;
                    r_clrBusy <= 1'b0;
                    r_clrDone <= 1'b1;
                end else begin
                    r_counter <= r_counter + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kgd_vram_arbiter.sv
// tb_kgd_vram_arbiter
// Drives the arbiter against a byte-wide synchronous RAM model and compares
// against an expected-memory array, sweep order and per-sweep cycle budgets.
`timescale 1ns/1ps
module tb_kgd_vram_arbiter;

    localparam int AW       = 14;
    localparam int CLR_LAST = 15;
    localparam int DEPTH    = 1 << AW;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;

    kgd_vram_arbiter_if #(.AW(AW)) bus ();

    kgd_vram_arbiter #(
        .AW       (AW),
        .CLR_LAST (CLR_LAST)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]    ramMem [DEPTH] = '{default: 8'h00};
    logic [7:0]    refMem [DEPTH] = '{default: 8'h00};
    int            wrCount [DEPTH] = '{default: 0};
    logic          capWe   = 1'b0;
    logic [AW-1:0] capAddr = '0;
    logic [7:0]    capData = '0;
    int            busyCycles  = 0;
    int            doneCount   = 0;
    int            sweepWrites = 0;
    int            sweepIdx    = 0;
    int            totalWrites = 0;
    bit            donePending = 1'b0;
    logic [7:0]    sweepFill   = '0;
    int            busyBase    = 0;
    int            doneBase    = 0;
    int            sweepBase   = 0;

    // Free-running system clock.
    always #5 wb_clk_i = ~wb_clk_i;

    // Port A RAM: read-first, registered output one cycle after the address.
    always @(posedge wb_clk_i) begin
        if (capWe) ramMem[capAddr] <= capData;
        bus.vram_q <= ramMem[capAddr];
    end

    // Mid-cycle observer: latches the port for the RAM and tracks sweep order.
    always @(negedge wb_clk_i) begin
        capWe   = (bus.vram_wren === 1'b1);
        capAddr = bus.vram_addr;
        capData = bus.vram_data;
        if (bus.clr_busy === 1'b1) busyCycles++;
        if (bus.clr_done === 1'b1) doneCount++;
        if (donePending) begin
            checkOutput("doneAfterLast", {31'd0, bus.clr_done}, 32'd1);
            donePending = 1'b0;
        end
        if (bus.clr_busy !== 1'b1) sweepIdx = 0;
        if (capWe) begin
            totalWrites++;
            wrCount[capAddr]++;
            if (bus.clr_busy === 1'b1 && int'(capAddr) <= CLR_LAST) begin
                checkOutput("sweepAddr", 32'(capAddr), 32'(sweepIdx));
                checkOutput("sweepData", 32'(capData), 32'(sweepFill));
                if (sweepIdx == CLR_LAST) donePending = 1'b1;
                sweepIdx++;
                sweepWrites++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wbRelease();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    // Presents one access and leaves the bus held at the cycle after its ack.
    task automatic wbAccess(input logic we, input logic [AW-1:0] adr, input logic [7:0] dat,
                            output logic [7:0] rdat, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        rdat = '0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge wb_clk_i);
            if (bus.wb_ack_o === 1'b1) begin
                seen = 1'b1;
                rdat = bus.wb_dat_o;
            end else begin
                lat++;
            end
            nextCycle();
        end
        if (!seen) checkOutput("ackTimeout", 32'd0, 32'd1);
    endtask

    task automatic cpuWrite(input logic [AW-1:0] adr, input logic [7:0] dat);
        logic [7:0] rd;
        int lat;
        wbAccess(1'b1, adr, dat, rd, lat);
        wbRelease();
        checkOutput("wrLatency", 32'(lat), 32'd1);
        refMem[adr] = dat;
    endtask

    task automatic cpuRead(input logic [AW-1:0] adr);
        logic [7:0] rd;
        int lat;
        wbAccess(1'b0, adr, 8'h00, rd, lat);
        wbRelease();
        checkOutput("rdLatency", 32'(lat), 32'd2);
        checkOutput("rdData", 32'(rd), 32'(refMem[adr]));
    endtask

    task automatic beginSweep(input logic [7:0] fill);
        sweepFill = fill;
        busyBase  = busyCycles;
        doneBase  = doneCount;
        sweepBase = sweepWrites;
    endtask

    task automatic startClear(input logic [7:0] fill);
        beginSweep(fill);
        bus.clr_start = 1'b1;
        bus.clr_data  = fill;
        nextCycle();
        bus.clr_start = 1'b0;
        bus.clr_data  = 8'($urandom);
    endtask

    task automatic waitSweepAt(input int target);
        int n = 0;
        while (sweepIdx != target && n < 100) begin
            nextCycle();
            n++;
        end
        if (sweepIdx != target) checkOutput("sweepReachTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitSweepEnd();
        int n = 0;
        while (bus.clr_busy === 1'b1 && n < 400) begin
            nextCycle();
            n++;
        end
        if (bus.clr_busy === 1'b1) checkOutput("sweepEndTimeout", 32'd0, 32'd1);
        nextCycle();
    endtask

    // Sweep totals, then the whole cleared range must read back as the fill.
    task automatic finishSweep(input int expBusy);
        checkOutput("busyCycles", 32'(busyCycles - busyBase), 32'(expBusy));
        checkOutput("doneCount", 32'(doneCount - doneBase), 32'd1);
        checkOutput("sweepWrites", 32'(sweepWrites - sweepBase), 32'(CLR_LAST + 1));
        for (int i = 0; i <= CLR_LAST; i++) refMem[i] = sweepFill;
        for (int i = 0; i <= CLR_LAST; i++) cpuRead(AW'(i));
    endtask

    // Random CPU traffic above the cleared range while a sweep runs.
    task automatic applyStimulus(input int rounds);
        logic [AW-1:0] wrList[$];
        logic [AW-1:0] a;
        int stall;
        int n;
        for (int r = 0; r < rounds; r++) begin
            startClear(8'($urandom));
            stall = 0;
            n = 0;
            while (bus.clr_busy === 1'b1 && n < 300) begin
                case ($urandom_range(3, 0))
                    0: begin
                        a = AW'($urandom_range(DEPTH - 1, CLR_LAST + 1));
                        cpuWrite(a, 8'($urandom));
                        wrList.push_back(a);
                        stall += 2;
                    end
                    1: begin
                        if (wrList.size() > 0 && $urandom_range(1, 0) == 1)
                            a = wrList[$urandom_range(wrList.size() - 1, 0)];
                        else
                            a = AW'($urandom_range(DEPTH - 1, CLR_LAST + 1));
                        cpuRead(a);
                        stall += 3;
                    end
                    default: nextCycle();
                endcase
                n++;
            end
            waitSweepEnd();
            finishSweep(CLR_LAST + 1 + stall);
        end
        foreach (wrList[i]) cpuRead(wrList[i]);
    endtask

    // Hard stop in case something wedges beyond every local bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main scenario sequence.
    initial begin
        int b0, b1, b2, lat, wb;
        logic [7:0] rd;

        bus.wb_adr_i  = '0;
        bus.wb_dat_i  = '0;
        bus.wb_we_i   = 1'b0;
        bus.wb_cyc_i  = 1'b0;
        bus.wb_stb_i  = 1'b0;
        bus.clr_start = 1'b0;
        bus.clr_data  = '0;

        wb_rst_i = 1'b1;
        repeat (3) nextCycle();
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("rstAck", 32'(bus.wb_ack_o), 32'd0);
        checkOutput("rstDatO", 32'(bus.wb_dat_o), 32'd0);
        checkOutput("rstBusy", 32'(bus.clr_busy), 32'd0);
        checkOutput("rstDone", 32'(bus.clr_done), 32'd0);
        checkOutput("rstWren", 32'(bus.vram_wren), 32'd0);
        checkOutput("rstAddr", 32'(bus.vram_addr), 32'd0);
        checkOutput("rstData", 32'(bus.vram_data), 32'd0);
        nextCycle();

        $display("[TB] write then read");
        b0 = wrCount[14'h0123];
        cpuWrite(14'h0123, 8'h3A);
        checkOutput("wrOnce", 32'(wrCount[14'h0123] - b0), 32'd1);
        wb = totalWrites;
        cpuRead(14'h0123);
        checkOutput("rdNoWren", 32'(totalWrites - wb), 32'd0);

        $display("[TB] uncontended clear");
        startClear(8'hA5);
        waitSweepEnd();
        finishSweep(CLR_LAST + 1);

        $display("[TB] CPU read during clear");
        cpuWrite(14'h0100, 8'h5C);
        startClear(8'hA5);
        waitSweepAt(5);
        cpuRead(14'h0100);
        waitSweepEnd();
        finishSweep(CLR_LAST + 1 + 3);

        $display("[TB] clr_start while busy");
        startClear(8'hA5);
        waitSweepAt(8);
        bus.clr_start = 1'b1;
        bus.clr_data  = 8'h00;
        nextCycle();
        bus.clr_start = 1'b0;
        waitSweepEnd();
        finishSweep(CLR_LAST + 1);

        $display("[TB] reset mid-sweep");
        startClear(8'h3C);
        waitSweepAt(7);
        wb_rst_i = 1'b1;
        nextCycle();
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("midRstBusy", 32'(bus.clr_busy), 32'd0);
        checkOutput("midRstWren", 32'(bus.vram_wren), 32'd0);
        repeat (4) nextCycle();
        checkOutput("midRstNoDone", 32'(doneCount - doneBase), 32'd0);
        startClear(8'h3C);
        waitSweepEnd();
        finishSweep(CLR_LAST + 1);

        $display("[TB] clr_start with CPU write in same cycle");
        beginSweep(8'h66);
        bus.clr_start = 1'b1;
        bus.clr_data  = 8'h66;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        bus.wb_we_i   = 1'b1;
        bus.wb_adr_i  = 14'h0200;
        bus.wb_dat_i  = 8'h77;
        nextCycle();
        bus.clr_start = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("coAck", 32'(bus.wb_ack_o), 32'd1);
        checkOutput("coBusy", 32'(bus.clr_busy), 32'd1);
        nextCycle();
        wbRelease();
        refMem[14'h0200] = 8'h77;
        waitSweepEnd();
        finishSweep(CLR_LAST + 1 + 1);
        cpuRead(14'h0200);

        $display("[TB] back-to-back writes");
        b0 = wrCount[0];
        b1 = wrCount[1];
        b2 = wrCount[2];
        wbAccess(1'b1, 14'h0000, 8'h11, rd, lat);
        checkOutput("b2bLat0", 32'(lat), 32'd1);
        wbAccess(1'b1, 14'h0001, 8'h22, rd, lat);
        checkOutput("b2bLat1", 32'(lat), 32'd1);
        wbAccess(1'b1, 14'h0002, 8'h33, rd, lat);
        checkOutput("b2bLat2", 32'(lat), 32'd1);
        wbRelease();
        refMem[0] = 8'h11;
        refMem[1] = 8'h22;
        refMem[2] = 8'h33;
        repeat (2) nextCycle();
        checkOutput("b2bOnce0", 32'(wrCount[0] - b0), 32'd1);
        checkOutput("b2bOnce1", 32'(wrCount[1] - b1), 32'd1);
        checkOutput("b2bOnce2", 32'(wrCount[2] - b2), 32'd1);
        cpuRead(14'h0000);
        cpuRead(14'h0001);
        cpuRead(14'h0002);

        $display("[TB] randomized traffic during clears");
        applyStimulus(4);

        repeat (2) nextCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kgd_vram_arbiter.md
Name: kgd_vram_arbiter

Overview:
Single-port sequencer for port A of the KGD graphics VRAM (8-bit data, 14-bit address, synchronous read with registered output).
- Shares the port between the CPU Wishbone slave path and a hardware screen-clear engine.
- The CPU always has priority; the clear engine fills the remaining idle cycles.
- Sits between the KGD register/bus logic and the kgdvram port A pins. Port B (video scan) is untouched.

Parameters:
AW, 14, VRAM port A address width.
CLR_LAST, 16383, last address written by a clear sweep (sweep covers 0..CLR_LAST, CLR_LAST <= 2^AW-1).

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge.
wb_rst_i  in  1  synchronous reset, active-high.
wb_adr_i  in  AW  CPU byte address into VRAM.
wb_dat_i  in  8  CPU write data.
wb_dat_o  out  8  CPU read data, valid while wb_ack_o=1.
wb_we_i  in  1  1 = write cycle.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe.
wb_ack_o  out  1  one-cycle acknowledge.
clr_start  in  1  one-cycle pulse that starts a clear sweep.
clr_data  in  8  fill byte, sampled on the accepted clr_start.
clr_busy  out  1  clear sweep in progress.
clr_done  out  1  one-cycle pulse after the last fill write.
vram_addr  out  AW  to kgdvram address_a.
vram_data  out  8  to kgdvram data_a.
vram_wren  out  1  to kgdvram wren_a.
vram_q  in  8  from kgdvram q_a; valid one cycle after the address is presented.

Behaviour:
Reset:
- wb_ack_o=0, wb_dat_o=0, clr_busy=0, clr_done=0, vram_wren=0, vram_addr=0, vram_data=0.
- State goes to IDLE; the sweep counter and fill register are cleared.

Definitions:
- CPU request (req) = wb_cyc_i & wb_stb_i & ~wb_ack_o.
- All vram_* outputs are combinational from the state and registers. They are sampled by the BRAM at the same edge.

State machine IDLE / RD / ACK:
- IDLE, req & wb_we_i:
  - vram_addr=wb_adr_i, vram_data=wb_dat_i, vram_wren=1.
  - Next state ACK. Write latency is 1 cycle to ack.
- IDLE, req & ~wb_we_i:
  - vram_addr=wb_adr_i, vram_wren=0.
  - Next state RD.
- RD:
  - vram_addr held at wb_adr_i, vram_wren=0.
  - wb_dat_o <= vram_q at the end of the cycle. Next state ACK.
  - Read latency is 2 cycles from request to ack.
- ACK:
  - wb_ack_o=1 for exactly this cycle; vram_wren=0. Next state IDLE.
  - A master still holding stb in the following IDLE cycle starts a new access. This is classic single-cycle Wishbone behaviour.
- IDLE, no req, clr_busy=1:
  - vram_addr=counter, vram_data=fill, vram_wren=1, counter++.
  - If counter==CLR_LAST on this write: clr_busy<=0 and clr_done<=1 for the next cycle; the counter returns to 0.
- IDLE, no req, clr_busy=0: vram_wren=0, vram_addr=0.
- The clear engine never writes in RD or ACK states. Those cycles and any CPU-request cycle stall the sweep; the counter is held.

Clear start rules:
- clr_start with clr_busy=0: fill<=clr_data, counter<=0, clr_busy<=1. The first fill write occurs on the next free IDLE cycle.
- clr_start with clr_busy=1: ignored. The fill value and counter are unchanged; no restart.
- clr_start in the same cycle as a CPU request: both are accepted. The CPU is served first; the sweep begins when the port is free.
- clr_start in the same cycle as the final fill write (busy still 1): ignored.

Other rules:
- A CPU write to an address the sweep has not yet reached is overwritten later by the sweep. Software waits for clr_busy=0; no hazard logic is provided.
- Reset mid-sweep or mid-access aborts immediately: no clr_done, no ack.
- Counter width is AW; no wrap beyond CLR_LAST.
- Uncontended sweep throughput is 1 byte/clock, so a full sweep takes CLR_LAST+1 cycles.

Test Plan:
- Write then read: write 0x3A to 0x0123 (ack 1 cycle after stb, vram_wren=1 one cycle), then read 0x0123 -> ack 2 cycles after stb, wb_dat_o=0x3A; vram_wren never asserted on the read.
- Uncontended clear, CLR_LAST=15, clr_data=0xA5: exactly 16 consecutive writes to addresses 0..15 with data 0xA5; clr_busy high 16 cycles; clr_done single pulse on the cycle after the write to address 15; all 16 bytes read back as 0xA5.
- CPU interleave during clear (CLR_LAST=15): issue a CPU read of 0x0100 at sweep address 5 -> sweep stalls for 3 cycles (req, RD, ACK) and resumes at address 5; no address skipped or duplicated; total busy time = 16 + 3 cycles.
- clr_start pulsed again at sweep address 8 with clr_data=0x00: ignored; all 16 addresses end as 0xA5 and exactly one clr_done pulse occurs.
- wb_rst_i asserted at sweep address 7: clr_busy=0 and vram_wren=0 on the next cycle; no clr_done; a new clr_start restarts from address 0.
- Back-to-back CPU writes with stb held across ack to 0x0000, 0x0001, 0x0002: one ack per access, pattern ack/idle/ack/idle, and each address written exactly once.
